// File: rtl/frac_sad_select.sv
// Fractional SAD selector: accumulates 25 per-row quarter/half-pel SADs over a block,
// then scans the totals one per cycle and returns the cheapest offset over valid/ready.
module frac_sad_select #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [59:0]      sad_uq,
  input  logic [59:0]      sad_uh,
  input  logic [59:0]      sad_middle,
  input  logic [59:0]      sad_lh,
  input  logic [59:0]      sad_lq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] best_sad,
  output logic [2:0]       best_dx,
  output logic [2:0]       best_dy,
  output logic             sat
);

  localparam int unsigned FW     = 12;
  localparam int unsigned NF     = 5;
  localparam int unsigned NC     = NF * NF;
  localparam int unsigned CW     = 5;
  localparam int unsigned CENTER = 12;

  typedef enum logic [1:0] {ACCUM, SEARCH, OUTPUT} state_t;

  state_t           r_state, w_next;
  logic [ACC_W-1:0] r_acc [NC];
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_best;
  logic [2:0]       r_dx, r_dy;
  logic             r_sat, r_out_valid, r_in_ready;

  logic [59:0]      w_bus   [NF];
  logic [FW-1:0]    w_field [NC];
  logic [ACC_W:0]   w_wide  [NC];
  logic [ACC_W-1:0] w_sum   [NC];
  logic [NC-1:0]    w_ovf;
  logic [CW-1:0]    w_idx;
  logic [2:0]       w_v, w_j, w_cdx, w_cdy;
  logic [ACC_W-1:0] w_cand;
  logic             w_accept, w_load, w_done;

  // Accumulator index = vertical row (dy -2..+2) * 5 + horizontal slot (field 4..0).
  assign w_bus[0] = sad_uh;
  assign w_bus[1] = sad_uq;
  assign w_bus[2] = sad_middle;
  assign w_bus[3] = sad_lq;
  assign w_bus[4] = sad_lh;

  always_comb begin
    for (int v = 0; v < int'(NF); v++) begin
      for (int j = 0; j < int'(NF); j++) begin
        w_field[v*NF+j] = w_bus[v][FW*(NF-1-j) +: FW];
      end
    end
  end

  // Saturating per-accumulator add.
  always_comb begin
    for (int i = 0; i < int'(NC); i++) begin
      w_wide[i] = (ACC_W+1)'(r_acc[i]) + (ACC_W+1)'(w_field[i]);
      w_ovf[i]  = w_wide[i][ACC_W];
      w_sum[i]  = w_ovf[i] ? {ACC_W{1'b1}} : w_wide[i][ACC_W-1:0];
    end
  end

  // Scan: center first, then raster order skipping the center.
  always_comb begin
    if (r_cnt == '0)
      w_idx = CW'(CENTER);
    else if (r_cnt <= CW'(CENTER))
      w_idx = r_cnt - CW'(1);
    else
      w_idx = r_cnt;
    w_v    = 3'(w_idx / CW'(NF));
    w_j    = 3'(w_idx % CW'(NF));
    w_cand = r_acc[w_idx];
    w_cdy  = w_v - 3'd2;
    case (w_j)
      3'd0:    w_cdx = 3'b111;
      3'd1:    w_cdx = 3'b110;
      3'd3:    w_cdx = 3'b010;
      3'd4:    w_cdx = 3'b001;
      default: w_cdx = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ACCUM: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (in_last) w_next = SEARCH;
        end
      end
      SEARCH: begin
        w_load = (r_cnt == '0) || (w_cand < r_best);
        if (r_cnt == CW'(NC-1)) w_next = OUTPUT;
      end
      OUTPUT: begin
        if (r_out_valid && out_ready) begin
          w_done = 1'b1;
          w_next = ACCUM;
        end
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NC); i++) r_acc[i] <= '0;
      r_cnt       <= '0;
      r_best      <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_in_ready <= (w_next == ACCUM);
      r_cnt      <= (r_state == SEARCH) ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        for (int i = 0; i < int'(NC); i++) r_acc[i] <= w_sum[i];
        if (|w_ovf) r_sat <= 1'b1;
      end
      if (w_load) begin
        r_best <= w_cand;
        r_dx   <= w_cdx;
        r_dy   <= w_cdy;
      end
      // out_valid rises one cycle after the search completes.
      if (w_done) begin
        for (int i = 0; i < int'(NC); i++) r_acc[i] <= '0;
        r_sat       <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (r_state == OUTPUT) begin
        r_out_valid <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign best_sad  = r_best;
  assign best_dx   = r_dx;
  assign best_dy   = r_dy;
  assign sat       = r_sat;

endmodule

// File: tb/tb_frac_sad_select.sv
// Bench for frac_sad_select: directed table, random blocks against a 5x5 cost-grid
// model, plus backpressure and mid-search reset sequences.
module tb_frac_sad_select;

  localparam int ACC_W = 16;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_last, out_valid, out_ready, sat;
  logic [59:0]      sad_uq, sad_uh, sad_middle, sad_lh, sad_lq;
  logic [ACC_W-1:0] best_sad;
  logic [2:0]       best_dx, best_dy;

  frac_sad_select #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .sad_uq(sad_uq), .sad_uh(sad_uh), .sad_middle(sad_middle), .sad_lh(sad_lh),
    .sad_lq(sad_lq), .out_valid(out_valid), .out_ready(out_ready), .best_sad(best_sad),
    .best_dx(best_dx), .best_dy(best_dy), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fill; int sv; int sk; int sval; int nrows;
    int esad; int edx; int edy; int esat;
  } vec_t;

  int          n_pass = 0, n_total = 0;
  int          m_acc [5][5];   // [row: dy+2][field k]
  bit          m_sat;
  int          dx_of [5];
  logic [59:0] row_buf [5];    // uh, uq, middle, lq, lh
  vec_t        tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_clear();
    for (int v = 0; v < 5; v++) for (int k = 0; k < 5; k++) m_acc[v][k] = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_row();
    int s;
    for (int v = 0; v < 5; v++)
      for (int k = 0; k < 5; k++) begin
        s = m_acc[v][k] + int'(row_buf[v][12*k +: 12]);
        if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
        m_acc[v][k] = s;
      end
  endtask

  // Global minimum; the center wins if it attains it, else the first in raster order.
  task automatic model_best(output int s, output int dx, output int dy);
    int mn;
    bit found;
    mn = m_acc[2][2];
    for (int v = 0; v < 5; v++) for (int k = 0; k < 5; k++) if (m_acc[v][k] < mn) mn = m_acc[v][k];
    s = mn; dx = 0; dy = 0; found = (m_acc[2][2] == mn);
    for (int v = 0; v < 5; v++)
      for (int k = 4; k >= 0; k--)
        if (!found && m_acc[v][k] == mn) begin
          found = 1'b1; dx = dx_of[k]; dy = v - 2;
        end
  endtask

  task automatic fill_row(input int fill, input int sv, input int sk, input int sval);
    for (int v = 0; v < 5; v++)
      for (int k = 0; k < 5; k++)
        row_buf[v][12*k +: 12] = (v == sv && k == sk) ? 12'(sval) : 12'(fill);
  endtask

  task automatic drive_buses();
    sad_uh = row_buf[0]; sad_uq = row_buf[1]; sad_middle = row_buf[2];
    sad_lq = row_buf[3]; sad_lh = row_buf[4];
  endtask

  task automatic send_row(input bit last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    drive_buses();
    in_valid = 1'b1; in_last = last;
    for (int t = 0; t < 60 && !ok; t++) begin
      if (in_ready) begin
        @(posedge clk);
        model_row();
        ok = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!ok) chk("in_ready_wait", 0, 1);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_block(input string nm, input int esad, input int edx, input int edy,
                              input int esat, input bit do_hs);
    int n;
    n = 0;
    for (int t = 0; t < 80 && !out_valid; t++) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, n, 26);
    chk({nm, "_sad"}, int'(best_sad), esad);
    chk({nm, "_dx"}, int'($signed(best_dx)), edx);
    chk({nm, "_dy"}, int'($signed(best_dy)), edy);
    chk({nm, "_sat"}, int'(sat), esat);
    if (do_hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({nm, "_hs_valid"}, int'(out_valid), 0);
      chk({nm, "_hs_ready"}, int'(in_ready), 1);
      model_clear();
    end
  endtask

  initial begin
    int es, ex, ey, nr, lo_range;
    dx_of = '{1, 2, 0, -2, -1};
    tbl[0] = '{10,   2,  2, 0,    1,  0,     0,  0,  0};
    tbl[1] = '{5,    0,  3, 1,    4,  4,    -2, -2,  0};
    tbl[2] = '{7,   -1,  0, 0,    3,  21,    0,  0,  0};
    tbl[3] = '{4095, 3,  0, 4094, 20, 65535, 0,  0,  1};
    tbl[4] = '{100,  4,  1, 50,   2,  100,   2,  2,  0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    fill_row(0, -1, 0, 0); drive_buses();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_best_sad", int'(best_sad), 0);
    chk("rst_dx", int'(best_dx), 0);
    chk("rst_dy", int'(best_dy), 0);
    chk("rst_sat", int'(sat), 0);

    for (int i = 0; i < 5; i++) begin
      fill_row(tbl[i].fill, tbl[i].sv, tbl[i].sk, tbl[i].sval);
      for (int r = 0; r < tbl[i].nrows; r++) send_row(r == tbl[i].nrows - 1);
      finish_block($sformatf("tbl%0d", i), tbl[i].esad, tbl[i].edx, tbl[i].edy, tbl[i].esat, 1'b1);
    end

    for (int b = 0; b < 8; b++) begin
      nr = int'($urandom_range(1, 6));
      lo_range = (b % 2 == 0) ? 15 : 4095;
      for (int r = 0; r < nr; r++) begin
        for (int v = 0; v < 5; v++)
          for (int k = 0; k < 5; k++)
            row_buf[v][12*k +: 12] = 12'($urandom_range(0, lo_range));
        send_row(r == nr - 1);
      end
      model_best(es, ex, ey);
      finish_block($sformatf("rnd%0d", b), es, ex, ey, int'(m_sat), 1'b1);
    end

    // Backpressure: result must hold while rows are offered and refused.
    fill_row(9, 1, 4, 2);
    send_row(1'b0);
    send_row(1'b1);
    finish_block("bp", 4, -1, -1, 0, 1'b0);
    fill_row(1, -1, 0, 0);
    drive_buses();
    in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_sad", int'(best_sad), 4);
      chk("bp_dx", int'($signed(best_dx)), -1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_dx_retained", int'($signed(best_dx)), -1);
    model_clear();
    fill_row(20, 2, 0, 6);
    send_row(1'b1);
    finish_block("bp_next", 6, 1, 0, 0, 1'b1);

    // Asynchronous reset in the middle of the search.
    fill_row(50, -1, 0, 0);
    send_row(1'b1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready), 1);
    @(negedge clk) rst = 1'b0;
    model_clear();
    @(posedge clk); @(negedge clk);
    chk("postrst_ready", int'(in_ready), 1);
    chk("postrst_valid", int'(out_valid), 0);
    fill_row(3, 3, 0, 0);
    send_row(1'b1);
    finish_block("postrst", 0, 1, 1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
